// File: rtl/ycr1_wb_burst_arb.sv
// Two-master round-robin arbiter for the burst Wishbone memory port.
// Holds the grant for a whole burst, forces at least one idle cycle between
// bursts, counts beats, aborts stalled bursts and rejects zero-length bursts.
module ycr1_wb_burst_arb #(
  parameter int unsigned YCR1_WB_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned TMO_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     wbd_m0_stb_i,
  input  logic [YCR1_WB_WIDTH-1:0] wbd_m0_adr_i,
  input  logic                     wbd_m0_we_i,
  input  logic [YCR1_WB_WIDTH-1:0] wbd_m0_dat_i,
  input  logic [3:0]               wbd_m0_sel_i,
  input  logic [9:0]               wbd_m0_bl_i,
  output logic [YCR1_WB_WIDTH-1:0] wbd_m0_dat_o,
  output logic                     wbd_m0_ack_o,
  output logic                     wbd_m0_lack_o,
  output logic                     wbd_m0_err_o,

  input  logic                     wbd_m1_stb_i,
  input  logic [YCR1_WB_WIDTH-1:0] wbd_m1_adr_i,
  input  logic                     wbd_m1_we_i,
  input  logic [YCR1_WB_WIDTH-1:0] wbd_m1_dat_i,
  input  logic [3:0]               wbd_m1_sel_i,
  input  logic [9:0]               wbd_m1_bl_i,
  output logic [YCR1_WB_WIDTH-1:0] wbd_m1_dat_o,
  output logic                     wbd_m1_ack_o,
  output logic                     wbd_m1_lack_o,
  output logic                     wbd_m1_err_o,

  output logic                     wbd_mem_stb_o,
  output logic [YCR1_WB_WIDTH-1:0] wbd_mem_adr_o,
  output logic                     wbd_mem_we_o,
  output logic [YCR1_WB_WIDTH-1:0] wbd_mem_dat_o,
  output logic [3:0]               wbd_mem_sel_o,
  output logic [9:0]               wbd_mem_bl_o,
  input  logic [YCR1_WB_WIDTH-1:0] wbd_mem_dat_i,
  input  logic                     wbd_mem_ack_i,
  input  logic                     wbd_mem_lack_i,
  input  logic                     wbd_mem_err_i,

  output logic [1:0]               gnt_o,
  output logic                     tmo_o
);

  localparam logic             TmoEn  = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TmoMax = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             last_gnt_q;   // 1: M1 was granted last
  logic [9:0]       beat_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  logic                     busy;
  logic                     in_err;
  logic                     pick_m1;
  logic [9:0]               pick_bl;
  logic                     g_stb;
  logic [YCR1_WB_WIDTH-1:0] g_adr;
  logic                     g_we;
  logic [YCR1_WB_WIDTH-1:0] g_dat;
  logic [3:0]               g_sel;
  logic [9:0]               g_bl;
  logic                     beat_last;
  logic                     lack_fwd;

  // Request selection and granted-master mux
  always_comb begin
    busy      = (state_q == StBusy);
    in_err    = (state_q == StErr);
    // On a tie, the master that was not granted last wins
    pick_m1   = wbd_m1_stb_i & (~wbd_m0_stb_i | ~last_gnt_q);
    pick_bl   = pick_m1 ? wbd_m1_bl_i : wbd_m0_bl_i;
    g_stb     = gnt_q[1] ? wbd_m1_stb_i : wbd_m0_stb_i;
    g_adr     = gnt_q[1] ? wbd_m1_adr_i : wbd_m0_adr_i;
    g_we      = gnt_q[1] ? wbd_m1_we_i  : wbd_m0_we_i;
    g_dat     = gnt_q[1] ? wbd_m1_dat_i : wbd_m0_dat_i;
    g_sel     = gnt_q[1] ? wbd_m1_sel_i : wbd_m0_sel_i;
    g_bl      = gnt_q[1] ? wbd_m1_bl_i  : wbd_m0_bl_i;
    beat_last = ((beat_cnt_q + 10'd1) == g_bl);
    // Last beat is flagged even when the slave forgets lack
    lack_fwd  = busy & wbd_mem_ack_i & (wbd_mem_lack_i | beat_last);
  end

  // Slave-side and master-side output steering, all decoded from state
  always_comb begin
    wbd_mem_stb_o = busy & g_stb;
    wbd_mem_adr_o = busy ? g_adr : '0;
    wbd_mem_we_o  = busy & g_we;
    wbd_mem_dat_o = busy ? g_dat : '0;
    wbd_mem_sel_o = busy ? g_sel : '0;
    wbd_mem_bl_o  = busy ? g_bl  : '0;

    wbd_m0_dat_o  = (busy & gnt_q[0]) ? wbd_mem_dat_i : '0;
    wbd_m0_ack_o  = busy & gnt_q[0] & wbd_mem_ack_i;
    wbd_m0_lack_o = gnt_q[0] & lack_fwd;
    wbd_m0_err_o  = gnt_q[0] & ((busy & wbd_mem_err_i) | in_err);

    wbd_m1_dat_o  = (busy & gnt_q[1]) ? wbd_mem_dat_i : '0;
    wbd_m1_ack_o  = busy & gnt_q[1] & wbd_mem_ack_i;
    wbd_m1_lack_o = gnt_q[1] & lack_fwd;
    wbd_m1_err_o  = gnt_q[1] & ((busy & wbd_mem_err_i) | in_err);

    gnt_o         = gnt_q;
    tmo_o         = tmo_q;
  end

  // Arbitration FSM with beat counter and no-ack watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= 2'b00;
      last_gnt_q <= 1'b1;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wbd_m0_stb_i | wbd_m1_stb_i) begin
            gnt_q      <= pick_m1 ? 2'b10 : 2'b01;
            last_gnt_q <= pick_m1;
            beat_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            state_q    <= (pick_bl == 10'd0) ? StErr : StBusy;
          end
        end
        StBusy: begin
          if (wbd_mem_err_i || !g_stb) begin
            gnt_q   <= 2'b00;
            state_q <= StIdle;
          end else if (wbd_mem_ack_i) begin
            beat_cnt_q <= beat_cnt_q + 10'd1;
            tmo_cnt_q  <= '0;
            if (wbd_mem_lack_i || beat_last) begin
              gnt_q   <= 2'b00;
              state_q <= StIdle;
            end
          end else if (TmoEn && (tmo_cnt_q == TmoMax)) begin
            tmo_q   <= 1'b1;
            state_q <= StErr;
          end else if (tmo_cnt_q != TmoMax) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StErr: begin
          gnt_q   <= 2'b00;
          state_q <= StIdle;
        end
        default: begin
          gnt_q   <= 2'b00;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycr1_wb_burst_arb.sv
// Directed bench for ycr1_wb_burst_arb with a zero-wait burst slave model.
module tb_ycr1_wb_burst_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = 0, m0_dbase = 0;
  logic [3:0]  m0_sel = 4'hf;
  logic [9:0]  m0_bl = 0;
  logic        m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_dbase = 0;
  logic [3:0]  m1_sel = 4'hf;
  logic [9:0]  m1_bl = 0;
  logic [31:0] m0_dat, m1_dat;

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_lack, m0_err, m1_ack, m1_lack, m1_err;
  logic        mem_stb, mem_we;
  logic [31:0] mem_adr, mem_dat_o, mem_dat_i;
  logic [3:0]  mem_sel;
  logic [9:0]  mem_bl;
  logic        mem_ack, mem_lack, mem_err;
  logic [1:0]  gnt;
  logic        tmo;

  // Slave model knobs
  logic        slv_stall = 0, slv_nolack = 0, slv_err = 0;
  logic [9:0]  slv_beat;
  logic [31:0] slv_addr;
  logic [31:0] wr_mem [0:1023];

  int vectors = 0, miscompares = 0;
  int m0_beats = 0, m1_beats = 0, gap_viol = 0, xtalk = 0;
  logic prev_end = 0;
  logic [1:0] gnt_prev = 0;
  logic [1:0] glog [0:63];
  int glog_n = 0;

  always #5 clk = ~clk;

  ycr1_wb_burst_arb #(.YCR1_WB_WIDTH(32), .TIMEOUT(16), .TMO_W(16)) dut (
    .clk(clk), .rst(rst),
    .wbd_m0_stb_i(m0_stb), .wbd_m0_adr_i(m0_adr), .wbd_m0_we_i(m0_we),
    .wbd_m0_dat_i(m0_dat), .wbd_m0_sel_i(m0_sel), .wbd_m0_bl_i(m0_bl),
    .wbd_m0_dat_o(m0_dat_o), .wbd_m0_ack_o(m0_ack), .wbd_m0_lack_o(m0_lack),
    .wbd_m0_err_o(m0_err),
    .wbd_m1_stb_i(m1_stb), .wbd_m1_adr_i(m1_adr), .wbd_m1_we_i(m1_we),
    .wbd_m1_dat_i(m1_dat), .wbd_m1_sel_i(m1_sel), .wbd_m1_bl_i(m1_bl),
    .wbd_m1_dat_o(m1_dat_o), .wbd_m1_ack_o(m1_ack), .wbd_m1_lack_o(m1_lack),
    .wbd_m1_err_o(m1_err),
    .wbd_mem_stb_o(mem_stb), .wbd_mem_adr_o(mem_adr), .wbd_mem_we_o(mem_we),
    .wbd_mem_dat_o(mem_dat_o), .wbd_mem_sel_o(mem_sel), .wbd_mem_bl_o(mem_bl),
    .wbd_mem_dat_i(mem_dat_i), .wbd_mem_ack_i(mem_ack), .wbd_mem_lack_i(mem_lack),
    .wbd_mem_err_i(mem_err),
    .gnt_o(gnt), .tmo_o(tmo)
  );

  // Zero-wait slave: acks every cycle stb is high, read data encodes the address
  assign slv_addr  = mem_adr + {22'b0, slv_beat};
  assign mem_ack   = mem_stb & ~slv_stall;
  assign mem_lack  = mem_ack & ~slv_nolack & (slv_beat == (mem_bl - 10'd1));
  assign mem_err   = slv_err;
  assign mem_dat_i = {16'h5EAD, slv_addr[15:0]};
  assign m0_dat    = m0_dbase + {22'b0, slv_beat};
  assign m1_dat    = m1_dbase + {22'b0, slv_beat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             slv_beat <= '0;
    else if (!mem_stb)   slv_beat <= '0;
    else if (mem_ack)    slv_beat <= slv_beat + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (mem_ack && mem_we) wr_mem[slv_addr[9:0]] <= mem_dat_o;
  end

  // Bus monitor: beat counts, inter-burst gap, grant order, cross-talk
  always @(negedge clk) begin
    if (m0_ack) m0_beats <= m0_beats + 1;
    if (m1_ack) m1_beats <= m1_beats + 1;
    if (prev_end && mem_stb) gap_viol <= gap_viol + 1;
    prev_end <= (m0_ack && m0_lack) || (m1_ack && m1_lack);
    if (gnt_prev == 2'b00 && gnt != 2'b00 && glog_n < 64) begin
      glog[glog_n] <= gnt;
      glog_n       <= glog_n + 1;
    end
    gnt_prev <= gnt;
    if (gnt != 2'b01 && (m0_ack || m0_lack || m0_err || m0_dat_o != 0)) xtalk <= xtalk + 1;
    if (gnt != 2'b10 && (m1_ack || m1_lack || m1_err || m1_dat_o != 0)) xtalk <= xtalk + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the end of master m's burst (lack or err), then drop its stb
  task automatic burst_wait(input int m, input int budget);
    bit done = 0;
    int cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m == 0) done = (m0_ack && m0_lack) || m0_err;
      else        done = (m1_ack && m1_lack) || m1_err;
    end
    check("burst_done", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    if (m == 0) m0_stb = 0; else m1_stb = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int b0, b1, n0, cyc;
    bit done;

    // Reset values
    #1;
    check("rst_gnt", {30'b0, gnt}, 0);
    check("rst_mem_stb", {31'b0, mem_stb}, 0);
    check("rst_tmo", {31'b0, tmo}, 0);
    check("rst_m0_err", {31'b0, m0_err}, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // 1: M0 read bl=4 @0x100
    b0 = m0_beats; b1 = m1_beats;
    m0_adr = 32'h100; m0_bl = 10'd4; m0_we = 0; m0_stb = 1;
    @(negedge clk);
    check("t1_gap_stb", {31'b0, mem_stb}, 0);
    @(negedge clk);
    check("t1_gnt", {30'b0, gnt}, 32'h1);
    check("t1_mem_stb", {31'b0, mem_stb}, 1);
    check("t1_mem_adr", mem_adr, 32'h100);
    check("t1_rdata", m0_dat_o, 32'h5EAD0100);
    check("t1_m1_dat", m1_dat_o, 0);
    burst_wait(0, 20);
    check("t1_beats", m0_beats - b0, 4);
    check("t1_m1_beats", m1_beats - b1, 0);
    check("t1_gnt_idle", {30'b0, gnt}, 0);

    // 2: simultaneous requests after reset, then round-robin
    do_reset();
    n0 = glog_n;
    m0_adr = 32'h300; m0_bl = 10'd2; m1_adr = 32'h400; m1_bl = 10'd2; m1_we = 0;
    m0_stb = 1; m1_stb = 1;
    burst_wait(0, 20);
    burst_wait(1, 20);
    check("t2_first", {30'b0, glog[n0]}, 32'h1);
    check("t2_second", {30'b0, glog[n0+1]}, 32'h2);
    m0_stb = 1;
    burst_wait(0, 20);
    n0 = glog_n;
    m0_stb = 1; m1_stb = 1;
    burst_wait(1, 20);
    burst_wait(0, 20);
    check("t2_rr_first", {30'b0, glog[n0]}, 32'h2);
    check("t2_rr_second", {30'b0, glog[n0+1]}, 32'h1);

    // 3: M1 write bl=8, M0 requests mid-burst
    b0 = m0_beats; b1 = m1_beats; n0 = glog_n;
    m1_adr = 32'h200; m1_bl = 10'd8; m1_we = 1; m1_dbase = 32'hCAFE0000; m1_stb = 1;
    repeat (3) @(negedge clk);
    m0_adr = 32'h500; m0_bl = 10'd2; m0_stb = 1;
    burst_wait(1, 30);
    check("t3_m1_beats", m1_beats - b1, 8);
    check("t3_m0_beats", m0_beats - b0, 0);
    burst_wait(0, 20);
    check("t3_next_gnt", {30'b0, glog[n0+1]}, 32'h1);
    for (int i = 0; i < 8; i++) check("t3_mem", wr_mem[10'h200 + i[9:0]], 32'hCAFE0000 + i);
    m1_we = 0;

    // 4: watchdog with the slave never acking
    slv_stall = 1;
    m0_adr = 32'h600; m0_bl = 10'd4; m0_stb = 1;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk); cyc++; done = m0_err;
    end
    check("t4_latency", cyc, 18);
    check("t4_tmo", {31'b0, tmo}, 1);
    check("t4_mem_stb", {31'b0, mem_stb}, 0);
    check("t4_m0_ack", {31'b0, m0_ack}, 0);
    @(posedge clk); #1; m0_stb = 0; slv_stall = 0;
    @(negedge clk);
    check("t4_tmo_pulse", {31'b0, tmo}, 0);
    check("t4_err_pulse", {31'b0, m0_err}, 0);
    b0 = m0_beats;
    m0_bl = 10'd1; m0_stb = 1;
    burst_wait(0, 20);
    check("t4_recover", m0_beats - b0, 1);

    // 5: bl=0 rejection, then a single-beat burst
    m0_bl = 10'd0; m0_stb = 1;
    @(negedge clk);
    check("t5_no_stb_a", {31'b0, mem_stb}, 0);
    @(negedge clk);
    check("t5_err", {31'b0, m0_err}, 1);
    check("t5_no_stb_b", {31'b0, mem_stb}, 0);
    @(posedge clk); #1; m0_stb = 0;
    @(negedge clk);
    check("t5_err_gone", {31'b0, m0_err}, 0);
    check("t5_idle", {30'b0, gnt}, 0);
    @(posedge clk); #1;
    m0_adr = 32'h700; m0_bl = 10'd1; m0_stb = 1;
    @(negedge clk);
    @(negedge clk);
    check("t5_ack_lack", {30'b0, m0_ack, m0_lack}, 32'h3);
    @(posedge clk); #1; m0_stb = 0;

    // Missing slave lack: the arbiter ends the burst on the beat count
    slv_nolack = 1; b1 = m1_beats;
    m1_adr = 32'h800; m1_bl = 10'd3; m1_stb = 1;
    burst_wait(1, 20);
    check("nolack_beats", m1_beats - b1, 3);
    slv_nolack = 0;

    // Slave error forwarded in the same cycle
    m1_adr = 32'h900; m1_bl = 10'd4; m1_stb = 1;
    @(negedge clk);
    @(negedge clk);
    slv_err = 1; slv_stall = 1; #1;
    check("serr_m1", {31'b0, m1_err}, 1);
    check("serr_m0", {31'b0, m0_err}, 0);
    @(posedge clk); #1; slv_err = 0; slv_stall = 0; m1_stb = 0;
    check("serr_idle", {30'b0, gnt}, 0);

    // 6: reset during beat 3 of a bl=8 burst
    @(posedge clk); #1;
    m0_adr = 32'hA00; m0_bl = 10'd8; m0_stb = 1;
    repeat (4) @(negedge clk);
    rst = 1; #1;
    check("t6_mem_stb", {31'b0, mem_stb}, 0);
    check("t6_gnt", {30'b0, gnt}, 0);
    check("t6_ack", {31'b0, m0_ack}, 0);
    check("t6_dat", m0_dat_o, 0);
    check("t6_adr", mem_adr, 0);
    @(negedge clk);
    b0 = m0_beats;
    rst = 0;
    burst_wait(0, 30);
    check("t6_beats", m0_beats - b0, 8);

    check("gap_viol", gap_viol, 0);
    check("xtalk", xtalk, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
